// File: rtl/hazard_ctrl_pipe.sv
// Pipeline control/hazard unit: carries decoded control through E/M/W and drives
// the stall, flush, forwarding and datapath mux selects for the operand/writeback block.
module hazard_ctrl_pipe #(
  parameter int FALU_LAT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] D_opcode,
  input  logic [4:0] D_rd,
  input  logic [4:0] D_rs1,
  input  logic [4:0] D_rs2,
  input  logic       D_rd_fp,
  input  logic       D_rs1_fp,
  input  logic       D_rs2_fp,
  input  logic       E_b,
  output logic       stall_fd,
  output logic       stall_e,
  output logic       D_flush,
  output logic       E_flush,
  output logic       next_pc_sel,
  output logic       D_rs1_data_sel,
  output logic       D_rs2_data_sel,
  output logic [1:0] E_rs1_data_sel,
  output logic [1:0] E_rs2_data_sel,
  output logic       E_alu_op1_sel,
  output logic       E_alu_op2_sel,
  output logic       E_jb_op1_sel,
  output logic       E_alu_falu_sel,
  output logic       W_wb_sel,
  output logic       M_dm_w_en,
  output logic       W_wb_en,
  output logic       W_f_wb_en,
  output logic [4:0] W_rd
);
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FP     = 7'b1010011;
  localparam logic [6:0] OP_FLW    = 7'b0000111;
  localparam logic [6:0] OP_FSW    = 7'b0100111;

  localparam int             CW       = $clog2(FALU_LAT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(FALU_LAT - 1);

  // M and W only need destination info; source indices stop at E.
  typedef struct packed {
    logic       valid;
    logic [6:0] opcode;
    logic [4:0] rd;
    logic       rd_fp;
  } dst_t;

  typedef struct packed {
    dst_t       dst;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       rs1_fp;
    logic       rs2_fp;
  } ex_t;

  ex_t           d_ex, e_q, e_d;
  dst_t          m_q, m_d, w_q, w_d;
  logic [CW-1:0] falu_cnt_q, falu_cnt_d;

  logic e_is_ld, e_is_fp, falu_stall, taken, load_use, lu;
  logic d_rs1_rd, d_rs2_rd;

  // x0 writes are dropped entirely; f0 is a real register.
  function automatic logic writes(dst_t s);
    return s.valid && !(s.opcode inside {OP_STORE, OP_BRANCH, OP_FSW}) &&
           (s.rd_fp || (s.rd != 5'd0));
  endfunction

  function automatic logic hits(dst_t s, logic [4:0] r, logic fp);
    return writes(s) && (s.rd == r) && (s.rd_fp == fp);
  endfunction

  function automatic logic [1:0] fwd(dst_t m, dst_t w, logic [4:0] r, logic fp);
    if (hits(m, r, fp) && !(m.opcode inside {OP_LOAD, OP_FLW})) return 2'b01;
    if (hits(w, r, fp)) return 2'b00;
    return 2'b10;
  endfunction

  always_comb begin
    d_ex            = '0;
    d_ex.dst.valid  = 1'b1;
    d_ex.dst.opcode = D_opcode;
    d_ex.dst.rd     = D_rd;
    d_ex.dst.rd_fp  = D_rd_fp;
    d_ex.rs1        = D_rs1;
    d_ex.rs2        = D_rs2;
    d_ex.rs1_fp     = D_rs1_fp;
    d_ex.rs2_fp     = D_rs2_fp;

    d_rs1_rd = D_opcode inside {OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, OP_IMM,
                                OP_OP, OP_FP, OP_FLW, OP_FSW};
    d_rs2_rd = D_opcode inside {OP_BRANCH, OP_STORE, OP_OP, OP_FP, OP_FSW};

    e_is_ld    = e_q.dst.valid && (e_q.dst.opcode inside {OP_LOAD, OP_FLW});
    e_is_fp    = e_q.dst.valid && (e_q.dst.opcode == OP_FP);
    falu_stall = e_is_fp && (falu_cnt_q != CNT_LAST);
    taken      = e_q.dst.valid && ((e_q.dst.opcode == OP_JAL) || (e_q.dst.opcode == OP_JALR) ||
                                   ((e_q.dst.opcode == OP_BRANCH) && E_b));
    load_use   = e_is_ld && ((d_rs1_rd && hits(e_q.dst, D_rs1, D_rs1_fp)) ||
                             (d_rs2_rd && hits(e_q.dst, D_rs2, D_rs2_fp)));
    // A redirect kills the dependent instruction anyway, and a held E cannot take a new one.
    lu         = load_use && !taken && !falu_stall;
  end

  assign stall_e        = falu_stall;
  assign stall_fd       = falu_stall || lu;
  assign D_flush        = taken;
  assign E_flush        = taken || lu;
  assign next_pc_sel    = taken;

  assign D_rs1_data_sel = hits(w_q, D_rs1, D_rs1_fp);
  assign D_rs2_data_sel = hits(w_q, D_rs2, D_rs2_fp);
  assign E_rs1_data_sel = fwd(m_q, w_q, e_q.rs1, e_q.rs1_fp);
  assign E_rs2_data_sel = fwd(m_q, w_q, e_q.rs2, e_q.rs2_fp);

  assign E_alu_op1_sel  = e_q.dst.valid && !(e_q.dst.opcode inside {OP_AUIPC, OP_JAL, OP_JALR});
  assign E_alu_op2_sel  = e_q.dst.valid && (e_q.dst.opcode inside {OP_OP, OP_BRANCH, OP_FP});
  assign E_jb_op1_sel   = e_q.dst.valid && (e_q.dst.opcode == OP_JALR);
  assign E_alu_falu_sel = !e_is_fp;

  assign M_dm_w_en = m_q.valid && (m_q.opcode inside {OP_STORE, OP_FSW});
  assign W_wb_sel  = w_q.valid && (w_q.opcode inside {OP_LOAD, OP_FLW});
  assign W_wb_en   = writes(w_q) && !w_q.rd_fp;
  assign W_f_wb_en = writes(w_q) && w_q.rd_fp;
  assign W_rd      = w_q.rd;

  always_comb begin
    e_d        = d_ex;
    m_d        = e_q.dst;
    w_d        = m_q;
    falu_cnt_d = '0;
    if (falu_stall) begin
      e_d        = e_q;
      m_d        = '0;
      falu_cnt_d = falu_cnt_q + CW'(1);
    end else if (E_flush) begin
      e_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q        <= '0;
      m_q        <= '0;
      w_q        <= '0;
      falu_cnt_q <= '0;
    end else begin
      e_q        <= e_d;
      m_q        <= m_d;
      w_q        <= w_d;
      falu_cnt_q <= falu_cnt_d;
    end
  end

  // LUI only needs to be named for completeness of the opcode map.
  logic unused_lui;
  assign unused_lui = (OP_LUI == 7'b0) ? 1'b1 : 1'b0;
endmodule

// File: tb/tb_hazard_ctrl_pipe.sv
// Directed bench for hazard_ctrl_pipe: stimulus pushes per-cycle expectations into a
// scoreboard queue; a negedge monitor pops and compares them against the DUT.
module tb_hazard_ctrl_pipe;
  localparam logic [6:0] JALR = 7'b1100111, BR = 7'b1100011, LD = 7'b0000011;
  localparam logic [6:0] OP = 7'b0110011, OPFP = 7'b1010011, FLW = 7'b0000111;
  localparam logic [6:0] FSW = 7'b0100111;

  logic clk = 1'b0, rst_n;
  logic [6:0] D_opcode;
  logic [4:0] D_rd, D_rs1, D_rs2;
  logic D_rd_fp, D_rs1_fp, D_rs2_fp, E_b;
  logic stall_fd, stall_e, D_flush, E_flush, next_pc_sel, D_rs1_data_sel, D_rs2_data_sel;
  logic [1:0] E_rs1_data_sel, E_rs2_data_sel;
  logic E_alu_op1_sel, E_alu_op2_sel, E_jb_op1_sel, E_alu_falu_sel;
  logic W_wb_sel, M_dm_w_en, W_wb_en, W_f_wb_en;
  logic [4:0] W_rd;

  hazard_ctrl_pipe #(.FALU_LAT(3)) dut (
    .clk(clk), .rst_n(rst_n), .D_opcode(D_opcode), .D_rd(D_rd), .D_rs1(D_rs1), .D_rs2(D_rs2),
    .D_rd_fp(D_rd_fp), .D_rs1_fp(D_rs1_fp), .D_rs2_fp(D_rs2_fp), .E_b(E_b),
    .stall_fd(stall_fd), .stall_e(stall_e), .D_flush(D_flush), .E_flush(E_flush),
    .next_pc_sel(next_pc_sel), .D_rs1_data_sel(D_rs1_data_sel), .D_rs2_data_sel(D_rs2_data_sel),
    .E_rs1_data_sel(E_rs1_data_sel), .E_rs2_data_sel(E_rs2_data_sel),
    .E_alu_op1_sel(E_alu_op1_sel), .E_alu_op2_sel(E_alu_op2_sel), .E_jb_op1_sel(E_jb_op1_sel),
    .E_alu_falu_sel(E_alu_falu_sel), .W_wb_sel(W_wb_sel), .M_dm_w_en(M_dm_w_en),
    .W_wb_en(W_wb_en), .W_f_wb_en(W_f_wb_en), .W_rd(W_rd)
  );

  always #5 clk = ~clk;

  typedef enum int {F_SFD, F_SE, F_DFL, F_EFL, F_NPC, F_DR1, F_DR2, F_ER1, F_ER2,
                    F_OP1, F_OP2, F_JB, F_FALU, F_WBS, F_DMW, F_WBE, F_FWBE, F_WRD} fld_e;
  typedef struct { int cyc; fld_e f; int v; string nm; } exp_t;

  exp_t sb[$];
  int cyc = 0;
  int n_tests = 0, n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get_fld(fld_e f);
    case (f)
      F_SFD:  return int'(stall_fd);
      F_SE:   return int'(stall_e);
      F_DFL:  return int'(D_flush);
      F_EFL:  return int'(E_flush);
      F_NPC:  return int'(next_pc_sel);
      F_DR1:  return int'(D_rs1_data_sel);
      F_DR2:  return int'(D_rs2_data_sel);
      F_ER1:  return int'(E_rs1_data_sel);
      F_ER2:  return int'(E_rs2_data_sel);
      F_OP1:  return int'(E_alu_op1_sel);
      F_OP2:  return int'(E_alu_op2_sel);
      F_JB:   return int'(E_jb_op1_sel);
      F_FALU: return int'(E_alu_falu_sel);
      F_WBS:  return int'(W_wb_sel);
      F_DMW:  return int'(M_dm_w_en);
      F_WBE:  return int'(W_wb_en);
      F_FWBE: return int'(W_f_wb_en);
      default: return int'(W_rd);
    endcase
  endfunction

  // Monitor: every negedge, compare all expectations queued for this cycle.
  always @(negedge clk) begin
    exp_t e;
    int act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      n_tests++;
      act = get_fld(e.f);
      if (e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s: check for cycle %0d reached monitor at cycle %0d", e.nm, e.cyc, cyc);
      end else if (act != e.v) begin
        n_fail++;
        $display("FAIL %s (cycle %0d): got %0d, expected %0d", e.nm, cyc, act, e.v);
      end
    end
  end

  task automatic chk(string nm, fld_e f, int v);
    exp_t e;
    e.cyc = cyc; e.f = f; e.v = v; e.nm = nm;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                     logic rdfp, logic rs1fp, logic rs2fp);
    D_opcode = op; D_rd = rd; D_rs1 = rs1; D_rs2 = rs2;
    D_rd_fp = rdfp; D_rs1_fp = rs1fp; D_rs2_fp = rs2fp;
  endtask

  task automatic nop();
    drv(7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic drain();
    nop();
    E_b = 1'b0;
    repeat (4) step();
  endtask

  initial begin
    #100000;
    n_tests++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    rst_n = 1'b0;
    E_b   = 1'b0;
    nop();
    // Reset values
    step();
    chk("rst_stall_fd", F_SFD, 0);   chk("rst_stall_e", F_SE, 0);
    chk("rst_d_flush", F_DFL, 0);    chk("rst_e_flush", F_EFL, 0);
    chk("rst_npc", F_NPC, 0);        chk("rst_d_rs1", F_DR1, 0);
    chk("rst_e_rs1", F_ER1, 2);      chk("rst_e_rs2", F_ER2, 2);
    chk("rst_op1", F_OP1, 0);        chk("rst_op2", F_OP2, 0);
    chk("rst_jb", F_JB, 0);          chk("rst_falu_sel", F_FALU, 1);
    chk("rst_wb_sel", F_WBS, 0);     chk("rst_dm_w", F_DMW, 0);
    chk("rst_wb_en", F_WBE, 0);      chk("rst_f_wb_en", F_FWBE, 0);
    chk("rst_w_rd", F_WRD, 0);
    step();
    rst_n = 1'b1;

    // Load-use: lw x5 ; add x6,x5,x7
    drv(LD, 5, 1, 0, 0, 0, 0);
    step(); drv(OP, 6, 5, 7, 0, 0, 0);
    chk("lu_stall_fd", F_SFD, 1); chk("lu_e_flush", F_EFL, 1);
    chk("lu_stall_e", F_SE, 0);   chk("lu_d_flush", F_DFL, 0);
    step();
    chk("lu_once_stall", F_SFD, 0); chk("lu_once_flush", F_EFL, 0);
    step(); nop();
    chk("lu_fwd_w_rs1", F_ER1, 0); chk("lu_rs2_rf", F_ER2, 2);
    chk("lu_w_wb_sel", F_WBS, 1);  chk("lu_w_wb_en", F_WBE, 1); chk("lu_w_rd", F_WRD, 5);
    drain();

    // Forward priority: add x3 ; sub x3 ; or x4,x3,x3 ; add x8,x3,x0
    drv(OP, 3, 1, 2, 0, 0, 0);
    step(); drv(OP, 3, 1, 2, 0, 0, 0);
    step(); drv(OP, 4, 3, 3, 0, 0, 0);
    step(); drv(OP, 8, 3, 0, 0, 0, 0);
    chk("prio_rs1_m", F_ER1, 1); chk("prio_rs2_m", F_ER2, 1);
    chk("dbyp_rs1", F_DR1, 1);   chk("dbyp_rs2_x0", F_DR2, 0);
    chk("op_op1", F_OP1, 1);     chk("op_op2", F_OP2, 1); chk("op_jb", F_JB, 0);
    step(); nop();
    chk("w_fwd_rs1", F_ER1, 0);  chk("w_fwd_rs2_x0", F_ER2, 2);
    drain();

    // x0: add x0 ; add x1,x0,x0
    drv(OP, 0, 1, 2, 0, 0, 0);
    step(); drv(OP, 1, 0, 0, 0, 0, 0);
    step(); nop();
    chk("x0_rs1", F_ER1, 2); chk("x0_rs2", F_ER2, 2);
    step();
    chk("x0_no_wb", F_WBE, 0);
    drain();

    // Class: flw f2 ; beq x2,x2 ; add x5,x2,x2 ; fsw f2,(x1)
    drv(FLW, 2, 1, 0, 1, 0, 0);
    step(); drv(BR, 0, 2, 2, 0, 0, 0);
    chk("lu_class_stall", F_SFD, 0); chk("lu_class_flush", F_EFL, 0);
    step(); drv(OP, 5, 2, 2, 0, 0, 0);
    step(); drv(FSW, 0, 1, 2, 0, 0, 1);
    chk("cls_rs1", F_ER1, 2);       chk("cls_rs2", F_ER2, 2);
    chk("flw_f_wb_en", F_FWBE, 1);  chk("flw_wb_en", F_WBE, 0);
    chk("flw_wb_sel", F_WBS, 1);    chk("flw_w_rd", F_WRD, 2);
    chk("dbyp_fp_rs2", F_DR2, 1);   chk("dbyp_cls_rs1", F_DR1, 0);
    step(); nop();
    step();
    chk("fsw_dm_w", F_DMW, 1);
    drain();

    // JALR control selects
    drv(JALR, 1, 2, 0, 0, 0, 0);
    step(); nop();
    chk("jalr_jb", F_JB, 1);  chk("jalr_op1", F_OP1, 0);
    chk("jalr_op2", F_OP2, 0); chk("jalr_npc", F_NPC, 1);
    drain();

    // Taken branch
    drv(BR, 0, 1, 2, 0, 0, 0);
    step(); drv(OP, 10, 1, 1, 0, 0, 0); E_b = 1'b1;
    chk("tk_npc", F_NPC, 1); chk("tk_d_flush", F_DFL, 1);
    chk("tk_e_flush", F_EFL, 1); chk("tk_no_stall", F_SFD, 0);
    step(); nop(); E_b = 1'b0;
    chk("tk_once_npc", F_NPC, 0); chk("tk_once_dfl", F_DFL, 0); chk("tk_once_efl", F_EFL, 0);
    step();
    step(); chk("tk_young1_wb", F_WBE, 0);
    step(); chk("tk_young2_wb", F_WBE, 0);
    drain();

    // Not-taken branch
    drv(BR, 0, 1, 2, 0, 0, 0);
    step(); drv(OP, 11, 0, 0, 0, 0, 0); E_b = 1'b0;
    chk("nt_npc", F_NPC, 0); chk("nt_d_flush", F_DFL, 0); chk("nt_e_flush", F_EFL, 0);
    step(); nop();
    step();
    step(); chk("nt_wb_en", F_WBE, 1); chk("nt_w_rd", F_WRD, 11);
    drain();

    // FALU: fadd f1,f2,f3 ; fadd f4,f1,f1, then reset mid-stall
    drv(OPFP, 1, 2, 3, 1, 1, 1);
    step(); drv(OPFP, 4, 1, 1, 1, 1, 1);
    chk("fp_stall_fd1", F_SFD, 1); chk("fp_stall_e1", F_SE, 1);
    chk("fp_falu_sel", F_FALU, 0); chk("fp_no_eflush", F_EFL, 0);
    step();
    chk("fp_stall_fd2", F_SFD, 1); chk("fp_stall_e2", F_SE, 1);
    step();
    chk("fp_rel_fd", F_SFD, 0);  chk("fp_rel_e", F_SE, 0);
    chk("fp_rel_falu", F_FALU, 0); chk("fp_bubble1", F_FWBE, 0);
    step(); nop();
    chk("fp_dep_rs1", F_ER1, 1); chk("fp_dep_rs2", F_ER2, 1);
    chk("fp_dep_stall", F_SFD, 1); chk("fp_bubble2", F_FWBE, 0);
    step(); #2 rst_n = 1'b0;
    chk("rstmid_fd", F_SFD, 0);   chk("rstmid_e", F_SE, 0);
    chk("rstmid_falu", F_FALU, 1); chk("rstmid_fwb", F_FWBE, 0);
    chk("rstmid_rs1", F_ER1, 2);
    step(); rst_n = 1'b1;
    drv(OPFP, 1, 2, 3, 1, 1, 1);
    step(); nop();
    chk("fp2_stall1", F_SFD, 1); chk("fp2_stall_e1", F_SE, 1);
    step(); chk("fp2_stall2", F_SE, 1);
    step(); chk("fp2_rel_fd", F_SFD, 0); chk("fp2_rel_e", F_SE, 0);
    step(); chk("fp2_after", F_SE, 0);
    drain();

    @(negedge clk);
    #1;
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
